// File: rtl/bin_share_encoder_if.sv
// Handshake bundle for the share encoder: unshared word in, randomness in, boolean sharing out.
interface bin_share_encoder_if #(
    parameter int D = 2,
    parameter int W = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         in_data;
    logic                 rnd_valid;
    logic                 rnd_ready;
    logic [(D-1)*W-1:0]   rnd_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [D*W-1:0]       out_shares;

    modport slave (
        input  in_valid, in_data, rnd_valid, rnd_data, out_ready,
        output in_ready, rnd_ready, out_valid, out_shares
    );

    modport master (
        output in_valid, in_data, rnd_valid, rnd_data, out_ready,
        input  in_ready, rnd_ready, out_valid, out_shares
    );
endinterface

// File: rtl/bin_share_encoder.sv
// Boolean masking entry: W-bit word -> D bit-interleaved shares, 1-cycle latency, 2-entry output buffer;
// readies drop only on registered FULL occupancy. SHARE_ENC_CNT_EN adds a saturating fire counter port.
module bin_share_encoder #(
    parameter int D = 2,
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst,
    bin_share_encoder_if.slave  bus
`ifdef SHARE_ENC_CNT_EN
    ,
    output logic [15:0]         cnt_sharings
`endif
);
    localparam int SW = D * W;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t          state_q;
    logic            out_valid_q;
    logic [SW-1:0]   slot0_q;
    logic [SW-1:0]   slot1_q;
    logic [SW-1:0]   enc_d;
    logic            enc_acc;
    logic            space;
    logic            fire;
    logic            pop;

    // Space comes from registered occupancy only, so out_ready never reaches the readies.
    assign space         = (state_q != FULL);
    assign bus.in_ready  = bus.rnd_valid & space;
    assign bus.rnd_ready = bus.in_valid & space;
    assign fire          = bus.in_valid & bus.rnd_valid & space;
    assign pop           = out_valid_q & bus.out_ready;

    assign bus.out_valid  = out_valid_q;
    assign bus.out_shares = slot0_q;

    always_comb begin
        enc_d   = '0;
        enc_acc = 1'b0;
        for (int i = 0; i < W; i++) begin
            enc_acc = bus.in_data[i];
            for (int j = 1; j < D; j++) begin
                enc_d[D*i + j] = bus.rnd_data[(D-1)*i + (j-1)];
                enc_acc        = enc_acc ^ bus.rnd_data[(D-1)*i + (j-1)];
            end
            enc_d[D*i] = enc_acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            slot0_q     <= '0;
            slot1_q     <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (fire) begin
                        slot0_q     <= enc_d;
                        state_q     <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (fire && pop) begin
                        slot0_q <= enc_d;
                    end else if (fire) begin
                        slot1_q <= enc_d;
                        state_q <= FULL;
                    end else if (pop) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        slot0_q <= slot1_q;
                        state_q <= ONE;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHARE_ENC_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'h0000;
        end else if (fire && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'h0001;
        end
    end

    assign cnt_sharings = cnt_q;
`endif
endmodule

// File: tb/tb_bin_share_encoder.sv
// Directed and scoreboarded bench for bin_share_encoder at D=2, W=4.
module tb_bin_share_encoder;
    localparam int D = 2;
    localparam int W = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    bin_share_encoder_if #(.D(D), .W(W)) bus ();

`ifdef SHARE_ENC_CNT_EN
    logic [15:0] cnt;
`endif

    bin_share_encoder #(.D(D), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SHARE_ENC_CNT_EN
        ,
        .cnt_sharings (cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] recomb(input logic [D*W-1:0] s);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) r[i] = ^s[D*i +: D];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [W-1:0] dat, input logic [W-1:0] rnd);
        bus.in_data   = dat;
        bus.rnd_data  = rnd;
        bus.in_valid  = 1'b1;
        bus.rnd_valid = 1'b1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.rnd_valid = 1'b0;
    endtask

    logic             f;
    logic             p;
    logic [D*W-1:0]   ps;
    logic [W-1:0]     sb[$];
    bit               offering;
    int               sent;
    int               got;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.in_valid  = 1'b0;
        bus.rnd_valid = 1'b0;
        bus.in_data   = '0;
        bus.rnd_data  = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_shares", 64'(bus.out_shares), 64'h0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_rnd_ready", 64'(bus.rnd_ready), 64'd0);
        #2 rst = 1'b0;
        step();

        // Basic encoding: A with randomness 6 -> 0x78.
        offer(4'hA, 4'h6);
        #1;
        chk("basic_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        idle();
        chk("basic_out_valid", 64'(bus.out_valid), 64'd1);
        chk("basic_shares", 64'(bus.out_shares), 64'h78);
        chk("basic_recomb", 64'(recomb(bus.out_shares)), 64'hA);
        step();
        chk("basic_drain", 64'(bus.out_valid), 64'd0);

        // Word without randomness is never consumed.
        bus.in_data   = 4'h5;
        bus.rnd_data  = 4'h0;
        bus.in_valid  = 1'b1;
        bus.rnd_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("nornd_in_ready", 64'(bus.in_ready), 64'd0);
            chk("nornd_out_valid", 64'(bus.out_valid), 64'd0);
            step();
        end
        bus.rnd_valid = 1'b1;
        #1;
        chk("rnd_rise_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        idle();
        chk("rnd_rise_shares", 64'(bus.out_shares), 64'h11);
        chk("rnd_rise_valid", 64'(bus.out_valid), 64'd1);
        step();

        // Backpressure: fill with 1 and 2, 3 stalls, then drain in order.
        bus.out_ready = 1'b0;
        offer(4'h1, 4'hF);
        step();
        chk("bp_w1_shares", 64'(bus.out_shares), 64'hFE);
        offer(4'h2, 4'h3);
        #1;
        chk("bp_w2_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        chk("bp_hold_after_w2", 64'(bus.out_shares), 64'hFE);
        offer(4'h3, 4'h9);
        #1;
        chk("bp_full_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_full_rnd_ready", 64'(bus.rnd_ready), 64'd0);
        step();
        chk("bp_stable_shares", 64'(bus.out_shares), 64'hFE);
        chk("bp_stable_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_no_comb_path", 64'(bus.in_ready), 64'd0);
        step();
        chk("bp_pop1_shares", 64'(bus.out_shares), 64'h0B);
        chk("bp_pop1_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        idle();
        chk("bp_pop2_shares", 64'(bus.out_shares), 64'hC6);
        chk("bp_pop2_recomb", 64'(recomb(bus.out_shares)), 64'h3);
        step();
        chk("bp_empty", 64'(bus.out_valid), 64'd0);

        // Random streaming with toggling backpressure.
        sent     = 0;
        got      = 0;
        offering = 1'b0;
        for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            if (!offering && sent < 100 && $urandom_range(0, 3) != 0) begin
                offering     = 1'b1;
                bus.in_data  = 4'($urandom);
                bus.rnd_data = 4'($urandom);
            end
            bus.in_valid  = offering;
            bus.rnd_valid = offering;
            #1;
            f  = bus.in_valid & bus.in_ready;
            p  = bus.out_valid & bus.out_ready;
            ps = bus.out_shares;
            step();
            if (f) begin
                sb.push_back(bus.in_data);
                sent++;
                offering = 1'b0;
            end
            if (p) begin
                if (sb.size() == 0) chk("stream_extra_output", 64'd1, 64'd0);
                else chk("stream_data", 64'(recomb(ps)), 64'(sb.pop_front()));
                got++;
            end
        end
        idle();
        chk("stream_count", 64'(got), 64'd100);
        chk("stream_leftover", 64'(sb.size()), 64'd0);
        bus.out_ready = 1'b1;
        step();
        step();

        // Asynchronous reset while FULL.
        bus.out_ready = 1'b0;
        offer(4'h4, 4'h2);
        step();
        offer(4'h7, 4'h1);
        step();
        idle();
        chk("full_before_rst", 64'(bus.out_valid), 64'd1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst_shares", 64'(bus.out_shares), 64'h0);
        #2 rst = 1'b0;
        bus.out_ready = 1'b1;
        step();
        offer(4'hA, 4'h6);
        step();
        idle();
        chk("post_rst_valid", 64'(bus.out_valid), 64'd1);
        chk("post_rst_shares", 64'(bus.out_shares), 64'h78);
        step();

`ifdef SHARE_ENC_CNT_EN
        bus.out_ready = 1'b1;
        offer(4'h9, 4'h5);
        repeat (70000) @(posedge clk);
        #1;
        idle();
        chk("cnt_saturate", 64'(cnt), 64'hFFFF);
        #3 rst = 1'b1;
        #1;
        chk("cnt_reset", 64'(cnt), 64'h0);
        #2 rst = 1'b0;
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bin_share_encoder.md
# bin_share_encoder

Masking entry point for the boolean-masked datapath. Converts a W-bit unshared word into a d-share boolean sharing using (d-1)·W fresh random bits supplied by the PRNG. Uses the bit-interleaved share encoding that XOR-reduction recombination expects. A 2-entry output buffer sustains one sharing per cycle toward the masked core under backpressure.

## Interface
- d, default 2: number of shares, d ≥ 2.
- W, default 32: unshared word width, W ≥ 1.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- in_valid, input, 1: unshared word available.
- in_ready, output, 1: word consumed this cycle when in_valid is also high.
- in_data, input, W: unshared word.
- rnd_valid, input, 1: randomness available.
- rnd_ready, output, 1: randomness consumed this cycle when rnd_valid is also high.
- rnd_data, input, (d-1)·W: fresh randomness.
- out_valid, output, 1: sharing available.
- out_ready, input, 1: downstream accepts.
- out_shares, output, d·W: sharing. Share j of bit i is at out_shares[d·i + j].

## Operation
- Encoding for bit i:
  - Share j, for 1 ≤ j ≤ d-1: r = rnd_data[(d-1)·i + (j-1)].
  - Share 0: in_data[i] XOR all d-1 random bits of bit i.
  - The XOR reduction of out_shares[d·i +: d] equals in_data[i].
- Shares are computed combinationally before the buffer. in_data is never stored unshared.
- Join handshake, with space = (count != 2):
  - fire = in_valid & rnd_valid & space.
  - in_ready = rnd_valid & space.
  - rnd_ready = in_valid & space.
  - Input and randomness are always consumed together; neither is consumed alone.
- The buffer is a 2-entry FIFO (slot0 = head). Occupancy FSM:
  - EMPTY: fire → ONE.
  - ONE:
    - fire & pop → ONE. Head is replaced by the new sharing.
    - fire only → FULL.
    - pop only → EMPTY.
  - FULL: pop → ONE, slot1 moves to slot0. No fire is possible (space=0).
  - pop = out_valid & out_ready.
- Ordering: sharings leave strictly in acceptance order.
- Stability: while out_valid & !out_ready, out_shares and out_valid hold unchanged.
- Popped or unused slots keep their stale share contents. They are never combined with other slots.
- Reset mid-operation discards buffered sharings. Any partially offered input is not consumed.

## Timing
- Reset values:
  - out_valid = 0.
  - out_shares = 0 (both slots cleared).
  - in_ready = 0 and rnd_ready = 0, because readies gate on the valids.
  - FSM = EMPTY.
- Latency: a fire at edge t gives out_valid = 1 after edge t, with the sharing on out_shares.
- Throughput: 1 sharing/cycle when out_ready is held high.
- Backpressure:
  - With out_ready = 0, two fires fill the buffer.
  - While FULL, in_ready and rnd_ready are low.
  - They rise in the cycle after the first pop.
- There is no combinational path from out_ready to in_ready or rnd_ready. Space depends on registered occupancy only.
- in_ready depends combinationally on rnd_valid, and rnd_ready on in_valid. Upstream valids must not depend on the readies.

## Configuration
- SHARE_ENC_CNT_EN:
  - When defined: adds output port cnt_sharings [15:0].
    - Increments on every fire.
    - Saturates at 16'hFFFF.
    - Reset value 0.
  - When undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- d=2, W=4, reset released, out_ready=1. Drive in_data=4'hA, rnd_data=4'h6, both valid for one cycle → next cycle out_valid=1, out_shares=8'h78, whose per-bit XOR gives 4'hA.
- rnd_valid=0, in_valid=1 for 5 cycles → in_ready=0 throughout, no fire, out_valid stays 0. Raising rnd_valid fires in the same cycle.
- out_ready=0, 3 consecutive valid words 1,2,3 → first two accepted, in_ready=0 on the 3rd. Then out_ready=1 → outputs in order 1,2,3, each recombining correctly.
- Streaming 100 random words with out_ready toggling randomly → no loss, no duplicate, order preserved. Scoreboard XOR-recombines each sharing to match its input.
- Assert rst while FULL → out_valid=0 immediately (asynchronously), out_shares=0. After release, the first new word emerges with one-cycle latency.
- SHARE_ENC_CNT_EN defined, 70000 fires → cnt_sharings saturates at 16'hFFFF. Reset returns it to 0.
